spw_rx_decoder: RTL and testbench

Character-level SpaceWire receive decoder. It sits directly downstream of the DS/ISERDES receive channel and consumes the recovered serial bit stream in line order.
- Acquires character alignment on the first NULL.
- Splits the stream into data, control and time-code characters.
- Checks odd parity and escape-sequence legality.
- Raises disconnect on bit-stream silence.
All results go to the link state machine and the receive FIFO.

---
 rtl/spw_rx_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_spw_rx_decoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_rx_decoder.sv
// spw_rx_decoder -- character-level SpaceWire receive decoder.
//
// Consumes the recovered bit stream (one bit per bit_valid, line order),
// acquires alignment on the first NULL, then decodes data, control and
// time-code characters. It checks odd parity and ESC legality, and flags a
// disconnect when the line goes silent.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   rx_en          enable; low behaves like reset (partial char dropped)
//   bit_in         received bit
//   bit_valid      bit_in carries a new bit this cycle
//   aligned        character alignment held (after first NULL)
//   got_null       pulse per NULL
//   got_fct        pulse per FCT that is not part of a NULL
//   rx_char_valid  pulse, rx_char valid ({0,byte} / 9'h100 EOP / 9'h101 EEP)
//   got_time       pulse, time_out valid
//   parity_err     pulse on parity failure
//   esc_err        pulse on illegal ESC sequence
//   disc_err       pulse on disconnect timeout
module spw_rx_decoder #(
  parameter int DISC_CYCLES = 43,
  parameter int CNT_W       = $clog2(DISC_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       aligned,
  output logic       got_null,
  output logic       got_fct,
  output logic       rx_char_valid,
  output logic [8:0] rx_char,
  output logic       got_time,
  output logic [7:0] time_out,
  output logic       parity_err,
  output logic       esc_err,
  output logic       disc_err
);

  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_PAR  = 3'd1;
  localparam logic [2:0] ST_FLAG = 3'd2;
  localparam logic [2:0] ST_CTRL = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;

  // ESC followed by FCT, as the last 7 bits seen (oldest in bit 6).
  localparam logic [6:0] NULL_TAIL = 7'b1110100;

  logic [2:0]       state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic             prev_par_q, prev_par_d;
  logic             par_acc_q, par_acc_d;
  logic             esc_q, esc_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic             aligned_q, aligned_d;
  logic             got_null_q, got_null_d;
  logic             got_fct_q, got_fct_d;
  logic             rx_char_valid_q, rx_char_valid_d;
  logic [8:0]       rx_char_q, rx_char_d;
  logic             got_time_q, got_time_d;
  logic [7:0]       time_out_q, time_out_d;
  logic             parity_err_q, parity_err_d;
  logic             esc_err_q, esc_err_d;
  logic             disc_err_q, disc_err_d;
  logic             err;

  always_comb begin
    state_d         = state_q;
    sr_d            = sr_q;
    bcnt_d          = bcnt_q;
    prev_par_d      = prev_par_q;
    par_acc_d       = par_acc_q;
    esc_d           = esc_q;
    started_d       = started_q;
    disc_cnt_d      = disc_cnt_q;
    got_null_d      = 1'b0;
    got_fct_d       = 1'b0;
    rx_char_valid_d = 1'b0;
    rx_char_d       = rx_char_q;
    got_time_d      = 1'b0;
    time_out_d      = time_out_q;
    parity_err_d    = 1'b0;
    esc_err_d       = 1'b0;
    disc_err_d      = 1'b0;
    err             = 1'b0;

    // Silence detector; a bit in the expiring cycle restarts the count.
    if (bit_valid) begin
      started_d  = 1'b1;
      disc_cnt_d = '0;
    end else if (started_q) begin
      if (disc_cnt_q == CNT_W'(DISC_CYCLES - 1)) begin
        disc_err_d = 1'b1;
        err        = 1'b1;
      end else begin
        disc_cnt_d = disc_cnt_q + CNT_W'(1);
      end
    end

    // par_acc holds P ^ F ^ (previous payload parity); 1 means odd = good.
    // esc_q stands in for the ESC-pending state: the next character runs
    // through the normal PAR/FLAG/CTRL/DATA path but decodes differently.
    if (bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          sr_d = {sr_q[6:0], bit_in};
          if (sr_d[6:0] == NULL_TAIL) begin
            got_null_d = 1'b1;
            state_d    = ST_PAR;
            prev_par_d = 1'b0;
            sr_d       = '0;
            esc_d      = 1'b0;
          end
        end
        ST_PAR: begin
          par_acc_d = prev_par_q ^ bit_in;
          state_d   = ST_FLAG;
        end
        ST_FLAG: begin
          par_acc_d = par_acc_q ^ bit_in;
          sr_d      = '0;
          bcnt_d    = '0;
          state_d   = bit_in ? ST_CTRL : ST_DATA;
        end
        ST_CTRL: begin
          sr_d   = {bit_in, sr_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd1) begin
            // c0 arrived first and now sits in bit 6, c1 in bit 7.
            prev_par_d = sr_d[7] ^ sr_d[6];
            state_d    = ST_PAR;
            if (!par_acc_q) begin
              parity_err_d = 1'b1;
              err          = 1'b1;
            end else if (esc_q) begin
              esc_d = 1'b0;
              if (sr_d[7:6] == 2'b00) begin
                got_null_d = 1'b1;
              end else begin
                esc_err_d = 1'b1;
                err       = 1'b1;
              end
            end else begin
              case ({sr_d[6], sr_d[7]})
                2'b00: got_fct_d = 1'b1;
                2'b01: begin
                  rx_char_valid_d = 1'b1;
                  rx_char_d       = 9'h100;
                end
                2'b10: begin
                  rx_char_valid_d = 1'b1;
                  rx_char_d       = 9'h101;
                end
                default: esc_d = 1'b1;
              endcase
            end
          end
        end
        ST_DATA: begin
          sr_d   = {bit_in, sr_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            prev_par_d = ^sr_d;
            state_d    = ST_PAR;
            if (!par_acc_q) begin
              parity_err_d = 1'b1;
              err          = 1'b1;
            end else if (esc_q) begin
              esc_d      = 1'b0;
              got_time_d = 1'b1;
              time_out_d = sr_d;
            end else begin
              rx_char_valid_d = 1'b1;
              rx_char_d       = {1'b0, sr_d};
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (err) begin
      state_d    = ST_HUNT;
      sr_d       = '0;
      bcnt_d     = '0;
      prev_par_d = 1'b0;
      par_acc_d  = 1'b0;
      esc_d      = 1'b0;
      started_d  = 1'b0;
      disc_cnt_d = '0;
    end

    aligned_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst || !rx_en) begin
      state_q         <= ST_HUNT;
      sr_q            <= '0;
      bcnt_q          <= '0;
      prev_par_q      <= 1'b0;
      par_acc_q       <= 1'b0;
      esc_q           <= 1'b0;
      started_q       <= 1'b0;
      disc_cnt_q      <= '0;
      aligned_q       <= 1'b0;
      got_null_q      <= 1'b0;
      got_fct_q       <= 1'b0;
      rx_char_valid_q <= 1'b0;
      rx_char_q       <= '0;
      got_time_q      <= 1'b0;
      time_out_q      <= '0;
      parity_err_q    <= 1'b0;
      esc_err_q       <= 1'b0;
      disc_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      bcnt_q          <= bcnt_d;
      prev_par_q      <= prev_par_d;
      par_acc_q       <= par_acc_d;
      esc_q           <= esc_d;
      started_q       <= started_d;
      disc_cnt_q      <= disc_cnt_d;
      aligned_q       <= aligned_d;
      got_null_q      <= got_null_d;
      got_fct_q       <= got_fct_d;
      rx_char_valid_q <= rx_char_valid_d;
      rx_char_q       <= rx_char_d;
      got_time_q      <= got_time_d;
      time_out_q      <= time_out_d;
      parity_err_q    <= parity_err_d;
      esc_err_q       <= esc_err_d;
      disc_err_q      <= disc_err_d;
    end
  end

  assign aligned       = aligned_q;
  assign got_null      = got_null_q;
  assign got_fct       = got_fct_q;
  assign rx_char_valid = rx_char_valid_q;
  assign rx_char       = rx_char_q;
  assign got_time      = got_time_q;
  assign time_out      = time_out_q;
  assign parity_err    = parity_err_q;
  assign esc_err       = esc_err_q;
  assign disc_err      = disc_err_q;

endmodule

// File: tb/tb_spw_rx_decoder.sv
// Testbench for spw_rx_decoder: scenario table, hand-written corner
// sequences and a randomized character stream, all checked every cycle
// against a character-level reference model.
module tb_spw_rx_decoder;
  localparam int DISC = 43;

  // Character codes: [9]=corrupt parity, [8]=control, [7:0]=byte or c-bits
  // with c0 in bit 0.
  localparam logic [9:0] C_FCT = 10'h100;
  localparam logic [9:0] C_EEP = 10'h101;
  localparam logic [9:0] C_EOP = 10'h102;
  localparam logic [9:0] C_ESC = 10'h103;
  localparam logic [9:0] BADP  = 10'h200;

  logic clk = 1'b0;
  logic rst, rx_en, bit_in, bit_valid;
  logic aligned, got_null, got_fct, rx_char_valid, got_time;
  logic parity_err, esc_err, disc_err;
  logic [8:0] rx_char;
  logic [7:0] time_out;

  always #5 clk = ~clk;

  spw_rx_decoder #(.DISC_CYCLES(DISC)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .bit_in(bit_in), .bit_valid(bit_valid),
    .aligned(aligned), .got_null(got_null), .got_fct(got_fct),
    .rx_char_valid(rx_char_valid), .rx_char(rx_char), .got_time(got_time),
    .time_out(time_out), .parity_err(parity_err), .esc_err(esc_err),
    .disc_err(disc_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state.
  bit m_aligned, m_esc, m_started;
  int m_idle, m_prev_ones;
  bit m_hist[$];
  bit m_cur[$];
  logic [8:0] m_char;
  logic [7:0] m_time;
  bit e_null, e_fct, e_cv, e_time, e_par, e_esc, e_disc;

  int c_null, c_fct, c_char, c_time, c_par, c_esc, c_disc;
  bit tb_prev;

  task automatic model_step(input bit r, input bit en, input bit bv, input bit b);
    bit err;
    int ones, pay, v;
    bit is_ctrl;
    {e_null, e_fct, e_cv, e_time, e_par, e_esc, e_disc} = '0;
    if (r || !en) begin
      m_aligned = 0; m_esc = 0; m_started = 0; m_idle = 0;
      m_hist.delete(); m_cur.delete(); m_char = '0; m_time = '0;
      return;
    end
    err = 0;
    if (bv) begin
      m_idle = 0; m_started = 1;
    end else if (m_started) begin
      m_idle++;
      if (m_idle == DISC) begin e_disc = 1; err = 1; end
    end
    if (bv) begin
      if (!m_aligned) begin
        m_hist.push_back(b);
        if (m_hist.size() > 7) void'(m_hist.pop_front());
        if (m_hist.size() == 7 && m_hist[0] && m_hist[1] && m_hist[2] && !m_hist[3]
            && m_hist[4] && !m_hist[5] && !m_hist[6]) begin
          e_null = 1; m_aligned = 1; m_prev_ones = 0; m_esc = 0;
          m_hist.delete();
        end
      end else begin
        m_cur.push_back(b);
        if (m_cur.size() >= 2 && m_cur.size() == (m_cur[1] ? 4 : 10)) begin
          ones = m_prev_ones + int'(m_cur[0]) + int'(m_cur[1]);
          pay = 0; v = 0;
          for (int i = 2; i < m_cur.size(); i++)
            if (m_cur[i]) begin pay++; v |= (1 << (i - 2)); end
          m_prev_ones = pay;
          is_ctrl = m_cur[1];
          m_cur.delete();
          if (ones % 2 == 0) begin
            e_par = 1; err = 1;
          end else if (m_esc) begin
            m_esc = 0;
            if (is_ctrl && v == 0) e_null = 1;
            else if (!is_ctrl) begin e_time = 1; m_time = v[7:0]; end
            else begin e_esc = 1; err = 1; end
          end else if (is_ctrl) begin
            case (v)
              0: e_fct = 1;
              1: begin e_cv = 1; m_char = 9'h101; end
              2: begin e_cv = 1; m_char = 9'h100; end
              default: m_esc = 1;
            endcase
          end else begin
            e_cv = 1; m_char = {1'b0, v[7:0]};
          end
        end
      end
    end
    if (err) begin
      m_aligned = 0; m_esc = 0; m_started = 0; m_idle = 0;
      m_hist.delete(); m_cur.delete();
    end
  endtask

  task automatic cycle(input bit r, input bit en, input bit bv, input bit b);
    logic [24:0] act, exp;
    rst = r; rx_en = en; bit_valid = bv; bit_in = b;
    @(posedge clk);
    model_step(r, en, bv, b);
    @(negedge clk);
    cyc++;
    act = {aligned, got_null, got_fct, rx_char_valid, rx_char, got_time, time_out,
           parity_err, esc_err, disc_err};
    exp = {m_aligned, e_null, e_fct, e_cv, m_char, e_time, m_time, e_par, e_esc, e_disc};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model cycle %0d: got %h expected %h", cyc, act, exp);
    end
    c_null += int'(got_null); c_fct += int'(got_fct); c_char += int'(rx_char_valid);
    c_time += int'(got_time); c_par += int'(parity_err); c_esc += int'(esc_err);
    c_disc += int'(disc_err);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    {c_null, c_fct, c_char, c_time, c_par, c_esc, c_disc} = '0;
  endtask

  task automatic send_char(input logic [9:0] code, input bit rgap);
    logic [7:0] pay;
    bit bits[10];
    bit p, f;
    int n;
    f = code[8];
    n = f ? 4 : 10;
    pay = f ? {6'b0, code[1:0]} : code[7:0];
    p = 1'b1 ^ f ^ tb_prev;
    if (code[9]) p = ~p;
    bits[0] = p; bits[1] = f;
    for (int i = 0; i < n - 2; i++) bits[i + 2] = pay[i];
    tb_prev = ^pay;
    for (int i = 0; i < n; i++) begin
      if (rgap && $urandom_range(0, 9) == 0)
        repeat ($urandom_range(1, 2)) cycle(0, 1, 0, 0);
      cycle(0, 1, 1, bits[i]);
    end
  endtask

  task automatic send_null();
    send_char(C_ESC, 0);
    send_char(C_FCT, 0);
  endtask

  task automatic do_reset();
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    tb_prev = 0;
    clr_counts();
  endtask

  typedef struct {
    int nch;
    logic [5:0][9:0] ch;
    int n_null, n_fct, n_char;
    int last_char;
    int n_time, last_time, n_par, n_esc, al;
  } scen_t;

  function automatic logic [5:0][9:0] mk(input logic [9:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  scen_t sc[10];

  initial begin
    sc[0] = '{4, mk(C_ESC, C_FCT, 10'h0A5, C_EOP, 0, 0), 1, 0, 2, 'h100, 0, 0, 0, 0, 1};
    sc[1] = '{4, mk(C_ESC, C_FCT, C_ESC, 10'h03F, 0, 0), 1, 0, 0, 0, 1, 'h3F, 0, 0, 1};
    sc[2] = '{5, mk(C_ESC, C_FCT, BADP | 10'h05A, C_ESC, C_FCT, 0), 2, 0, 0, 0, 0, 0, 1, 0, 1};
    sc[3] = '{4, mk(C_ESC, C_FCT, C_ESC, C_EOP, 0, 0), 1, 0, 0, 0, 0, 0, 0, 1, 0};
    sc[4] = '{5, mk(C_ESC, C_FCT, C_FCT, C_EEP, 10'h000, 0), 1, 1, 2, 'h000, 0, 0, 0, 0, 1};
    sc[5] = '{4, mk(C_ESC, C_FCT, C_ESC, C_FCT, 0, 0), 2, 0, 0, 0, 0, 0, 0, 0, 1};
    sc[6] = '{4, mk(C_ESC, C_FCT, C_ESC, C_ESC, 0, 0), 1, 0, 0, 0, 0, 0, 0, 1, 0};
    sc[7] = '{3, mk(C_ESC, C_FCT, BADP | C_FCT, 0, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0, 0};
    sc[8] = '{4, mk(10'h0FF, C_ESC, C_FCT, 10'h081, 0, 0), 1, 0, 1, 'h081, 0, 0, 0, 0, 1};
    sc[9] = '{4, mk(C_ESC, C_FCT, C_ESC, BADP | C_EOP, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0, 0};

    @(negedge clk);
    do_reset();
    chk("reset_outputs", int'({aligned, got_null, got_fct, rx_char_valid, rx_char, got_time,
                              time_out, parity_err, esc_err, disc_err}), 0);

    // Scenario table.
    for (int s = 0; s < 10; s++) begin
      do_reset();
      for (int k = 0; k < sc[s].nch; k++) send_char(sc[s].ch[k], 0);
      repeat (3) cycle(0, 1, 0, 0);
      chk($sformatf("s%0d null", s), c_null, sc[s].n_null);
      chk($sformatf("s%0d fct", s), c_fct, sc[s].n_fct);
      chk($sformatf("s%0d chars", s), c_char, sc[s].n_char);
      chk($sformatf("s%0d last_char", s), int'(rx_char), sc[s].last_char);
      chk($sformatf("s%0d time", s), c_time, sc[s].n_time);
      chk($sformatf("s%0d time_out", s), int'(time_out), sc[s].last_time);
      chk($sformatf("s%0d parity_err", s), c_par, sc[s].n_par);
      chk($sformatf("s%0d esc_err", s), c_esc, sc[s].n_esc);
      chk($sformatf("s%0d aligned", s), int'(aligned), sc[s].al);
    end

    // NULL latency: pulse exactly one cycle after the 8th bit.
    begin
      bit nb[8];
      nb = '{0, 1, 1, 1, 0, 1, 0, 0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
        cycle(0, 1, 1, nb[i]);
        chk($sformatf("null_lat bit%0d", i), int'(got_null), (i == 7) ? 1 : 0);
      end
      chk("null_lat aligned", int'(aligned), 1);
    end

    // Disconnect after exactly DISC silent cycles.
    repeat (DISC - 1) cycle(0, 1, 0, 0);
    chk("disc early", c_disc, 0);
    cycle(0, 1, 0, 0);
    chk("disc pulse", int'(disc_err), 1);
    chk("disc aligned", int'(aligned), 0);

    // A bit arriving in the expiring cycle suppresses the disconnect.
    tb_prev = 0;
    send_null();
    clr_counts();
    repeat (DISC - 1) cycle(0, 1, 0, 0);
    send_char(10'h0C3, 0);
    cycle(0, 1, 0, 0);
    chk("disc rescued", c_disc, 0);
    chk("disc rescued char", c_char, 1);
    chk("disc rescued aligned", int'(aligned), 1);

    // rx_en low mid-character: silent discard.
    do_reset();
    send_null();
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1'(i & 1));
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("rx_en errors", c_par + c_esc + c_disc, 0);
    chk("rx_en aligned", int'(aligned), 0);

    // Randomized character stream.
    do_reset();
    send_null();
    for (int n = 0; n < 500; n++) begin
      int a;
      logic [9:0] code;
      a = int'($urandom_range(0, 99));
      if (a < 2) begin
        cycle(0, 0, 0, 0);
      end else if (a < 3) begin
        cycle(1, 1, 0, 0);
        tb_prev = 0;
      end else if (a < 18) begin
        send_null();
      end else begin
        if ($urandom_range(0, 9) < 7) code = {2'b00, 8'($urandom)};
        else code = {2'b01, 6'b0, 2'($urandom)};
        if ($urandom_range(0, 19) == 0) code = code | BADP;
        send_char(code, 1);
      end
      a = int'($urandom_range(0, 99));
      if (a < 20) repeat ($urandom_range(1, 5)) cycle(0, 1, 0, 0);
      else if (a < 25) repeat ($urandom_range(DISC - 4, DISC + 4)) cycle(0, 1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
